// File: rtl/updown_counter_gen2.sv
// updown_counter_gen2
//   Loadable up/down event/timebase counter with a runtime terminal value
//   (limit), variable step size, a registered wrap pulse and sticky
//   overflow/underflow flags with software clear.
//
// Optional build macro: UPDOWN_COUNTER_SATURATE_EN
//   When defined, adds the sat_mode input. With sat_mode=1 an out-of-range
//   step clamps to limit (up) or 0 (down) instead of wrapping. The wrap pulse
//   and the matching sticky flag are still raised. Without the macro the
//   counter always wraps.
//
// Ports
//   clk         clock, all state changes on the rising edge
//   rst         synchronous active-high reset
//   load_n      active-low load strobe (load wins over counting)
//   data_load   load value, clamped to limit
//   ce          count enable
//   up_down     1 = up, 0 = down
//   step        increment/decrement amount (0 = hold)
//   limit       terminal value, legal count range is 0..limit
//   clr_sticky  clears ovf_sticky/udf_sticky (a same-cycle set wins)
//   sat_mode    (macro only) 1 = saturate instead of wrap
//   count_out   registered count
//   zero        count_out == 0 (combinational)
//   max_count   count_out == limit (combinational)
//   wrap_pulse  one-cycle registered pulse on any wrap/saturate event
//   ovf_sticky  set by an up-wrap
//   udf_sticky  set by a down-wrap

module updown_counter_gen2 #(
  parameter int WIDTH     = 8,
  parameter int STEP_W    = 4,
  parameter int RESET_VAL = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_n,
  input  logic [WIDTH-1:0]  data_load,
  input  logic              ce,
  input  logic              up_down,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  limit,
  input  logic              clr_sticky,
`ifdef UPDOWN_COUNTER_SATURATE_EN
  input  logic              sat_mode,
`endif
  output logic [WIDTH-1:0]  count_out,
  output logic              zero,
  output logic              max_count,
  output logic              wrap_pulse,
  output logic              ovf_sticky,
  output logic              udf_sticky
);

  logic              sat;
  logic [WIDTH-1:0]  step_ext;
  logic [WIDTH:0]    sum;
  logic              up_wrap;
  logic              dn_wrap;
  logic [WIDTH-1:0]  count_nxt;
  logic              wrap_nxt;
  logic              ovf_set;
  logic              udf_set;

`ifdef UPDOWN_COUNTER_SATURATE_EN
  assign sat = sat_mode;
`else
  assign sat = 1'b0;
`endif

  assign step_ext = WIDTH'(step);
  // One extra bit so a carry out of the top is seen as "beyond limit".
  assign sum      = {1'b0, count_out} + {1'b0, step_ext};
  // An up step from an out-of-range count always exceeds limit since
  // step is nonzero, so no separate range check is needed here.
  assign up_wrap  = sum > {1'b0, limit};
  // Down must treat count_out > limit (limit lowered at runtime) as a wrap
  // even when the subtraction itself would not borrow.
  assign dn_wrap  = (count_out > limit) || (step_ext > count_out);

  always_comb begin
    count_nxt = count_out;
    wrap_nxt  = 1'b0;
    ovf_set   = 1'b0;
    udf_set   = 1'b0;
    if (!load_n) begin
      count_nxt = (data_load > limit) ? limit : data_load;
    end else if (ce && (step != '0)) begin
      if (up_down) begin
        if (up_wrap) begin
          count_nxt = sat ? limit : '0;
          wrap_nxt  = 1'b1;
          ovf_set   = 1'b1;
        end else begin
          count_nxt = sum[WIDTH-1:0];
        end
      end else begin
        if (dn_wrap) begin
          count_nxt = sat ? '0 : limit;
          wrap_nxt  = 1'b1;
          udf_set   = 1'b1;
        end else begin
          count_nxt = count_out - step_ext;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_out  <= WIDTH'(RESET_VAL);
      wrap_pulse <= 1'b0;
      ovf_sticky <= 1'b0;
      udf_sticky <= 1'b0;
    end else begin
      count_out  <= count_nxt;
      wrap_pulse <= wrap_nxt;
      ovf_sticky <= ovf_set | (ovf_sticky & ~clr_sticky);
      udf_sticky <= udf_set | (udf_sticky & ~clr_sticky);
    end
  end

  assign zero      = (count_out == '0);
  assign max_count = (count_out == limit);

endmodule

// File: tb/tb_updown_counter_gen2.sv
module tb_updown_counter_gen2;

  localparam int WIDTH     = 8;
  localparam int STEP_W    = 4;
  localparam int RESET_VAL = 0;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              load_n = 1'b1;
  logic [WIDTH-1:0]  data_load = '0;
  logic              ce = 1'b0;
  logic              up_down = 1'b1;
  logic [STEP_W-1:0] step = '0;
  logic [WIDTH-1:0]  limit = '1;
  logic              clr_sticky = 1'b0;
`ifdef UPDOWN_COUNTER_SATURATE_EN
  logic              sat_mode = 1'b0;
`endif
  logic [WIDTH-1:0]  count_out;
  logic              zero;
  logic              max_count;
  logic              wrap_pulse;
  logic              ovf_sticky;
  logic              udf_sticky;

  int total = 0;
  int bad   = 0;

  // reference state
  int m_cnt  = RESET_VAL;
  bit m_wrap = 0;
  bit m_ovf  = 0;
  bit m_udf  = 0;

  updown_counter_gen2 #(.WIDTH(WIDTH), .STEP_W(STEP_W), .RESET_VAL(RESET_VAL)) dut (
    .clk(clk), .rst(rst), .load_n(load_n), .data_load(data_load), .ce(ce),
    .up_down(up_down), .step(step), .limit(limit), .clr_sticky(clr_sticky),
`ifdef UPDOWN_COUNTER_SATURATE_EN
    .sat_mode(sat_mode),
`endif
    .count_out(count_out), .zero(zero), .max_count(max_count),
    .wrap_pulse(wrap_pulse), .ovf_sticky(ovf_sticky), .udf_sticky(udf_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Next state from the behavioural rules, using plain integer arithmetic.
  task automatic model_edge();
    int lim, s, c;
    bit sat_on, oset, uset;
    lim = int'(limit);
    s   = int'(step);
    c   = m_cnt;
    oset = 0;
    uset = 0;
    sat_on = 0;
`ifdef UPDOWN_COUNTER_SATURATE_EN
    sat_on = sat_mode;
`endif
    if (rst) begin
      m_cnt = RESET_VAL; m_wrap = 0; m_ovf = 0; m_udf = 0;
      return;
    end
    m_wrap = 0;
    if (!load_n) begin
      m_cnt = (int'(data_load) < lim) ? int'(data_load) : lim;
    end else if (ce && s != 0) begin
      if (up_down) begin
        if (c + s > lim) begin
          m_cnt = sat_on ? lim : 0; m_wrap = 1; oset = 1;
        end else m_cnt = c + s;
      end else begin
        if (c > lim || s > c) begin
          m_cnt = sat_on ? 0 : lim; m_wrap = 1; uset = 1;
        end else m_cnt = c - s;
      end
    end
    m_ovf = oset || (m_ovf && !clr_sticky);
    m_udf = uset || (m_udf && !clr_sticky);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".count"}, 32'(count_out), 32'(m_cnt));
    chk({tag, ".zero"}, 32'(zero), 32'(m_cnt == 0));
    chk({tag, ".max"}, 32'(max_count), 32'(m_cnt == int'(limit)));
    chk({tag, ".wrap"}, 32'(wrap_pulse), 32'(m_wrap));
    chk({tag, ".ovf"}, 32'(ovf_sticky), 32'(m_ovf));
    chk({tag, ".udf"}, 32'(udf_sticky), 32'(m_udf));
  endtask

  // Apply one cycle of inputs, advance the model and compare after the edge.
  task automatic cyc(input string tag, input bit r, input bit ld_n, input int d,
                     input bit en, input bit ud, input int st, input int lim,
                     input bit clr);
    rst = r; load_n = ld_n; data_load = WIDTH'(d); ce = en; up_down = ud;
    step = STEP_W'(st); limit = WIDTH'(lim); clr_sticky = clr;
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    // reset during active counting from 0x37
    cyc("rst0", 1, 1, 0, 0, 1, 0, 255, 0);
    cyc("ld37", 0, 0, 8'h37, 0, 1, 0, 255, 0);
    chk("ld37.val", 32'(count_out), 32'h37);
    cyc("rstcnt", 1, 1, 0, 1, 1, 3, 255, 0);
    chk("rst.count", 32'(count_out), RESET_VAL);
    chk("rst.zero", 32'(zero), 1);

    // up wrap
    cyc("uw.ld", 0, 0, 7, 0, 1, 0, 9, 0);
    cyc("uw.c1", 0, 1, 0, 1, 1, 2, 9, 0);
    chk("uw.nine", 32'(count_out), 9);
    chk("uw.max", 32'(max_count), 1);
    cyc("uw.c2", 0, 1, 0, 1, 1, 2, 9, 0);
    chk("uw.zero", 32'(count_out), 0);
    chk("uw.pulse", 32'(wrap_pulse), 1);
    chk("uw.ovf", 32'(ovf_sticky), 1);
    cyc("uw.hold", 0, 1, 0, 0, 1, 2, 9, 0);
    chk("uw.pulse_end", 32'(wrap_pulse), 0);

    // down wrap with step, then clear racing a new wrap
    cyc("dw.ld", 0, 0, 3, 0, 0, 0, 20, 1);
    cyc("dw.c1", 0, 1, 0, 1, 0, 4, 20, 0);
    chk("dw.lim", 32'(count_out), 20);
    chk("dw.udf", 32'(udf_sticky), 1);
    cyc("dw.ld2", 0, 0, 2, 0, 0, 0, 20, 0);
    cyc("dw.race", 0, 1, 0, 1, 0, 4, 20, 1);
    chk("dw.race_udf", 32'(udf_sticky), 1);
    cyc("dw.clr", 0, 1, 0, 0, 0, 0, 20, 1);
    chk("dw.cleared", 32'(udf_sticky), 0);

    // load priority and clamp
    cyc("lc.ld", 0, 0, 200, 1, 1, 3, 10, 0);
    chk("lc.clamp", 32'(count_out), 10);
    chk("lc.nowrap", 32'(wrap_pulse), 0);
    cyc("lc.step0", 0, 1, 0, 1, 1, 0, 10, 0);
    chk("lc.held", 32'(count_out), 10);

    // runtime limit drop
    cyc("ld.ld50", 0, 0, 50, 0, 1, 0, 255, 0);
    cyc("ld.up", 0, 1, 0, 1, 1, 1, 30, 0);
    chk("ld.up0", 32'(count_out), 0);
    chk("ld.uppulse", 32'(wrap_pulse), 1);
    cyc("ld.ld50b", 0, 0, 50, 0, 1, 0, 255, 0);
    cyc("ld.hold", 0, 1, 0, 0, 0, 1, 30, 0);
    chk("ld.oor_hold", 32'(count_out), 50);
    cyc("ld.dn", 0, 1, 0, 1, 0, 1, 30, 0);
    chk("ld.dn30", 32'(count_out), 30);

    // limit = 0
    cyc("l0.up", 0, 1, 0, 1, 1, 1, 0, 0);
    cyc("l0.dn", 0, 1, 0, 1, 0, 5, 0, 0);
    chk("l0.zm", 32'({zero, max_count}), 3);

`ifdef UPDOWN_COUNTER_SATURATE_EN
    sat_mode = 1'b1;
    cyc("sat.ld", 0, 0, 14, 0, 1, 0, 15, 1);
    cyc("sat.up", 0, 1, 0, 1, 1, 3, 15, 0);
    chk("sat.up15", 32'(count_out), 15);
    chk("sat.ovf", 32'(ovf_sticky), 1);
    cyc("sat.up2", 0, 1, 0, 1, 1, 3, 15, 0);
    chk("sat.stay", 32'(count_out), 15);
    cyc("sat.ld2", 0, 0, 2, 0, 0, 0, 15, 0);
    cyc("sat.dn", 0, 1, 0, 1, 0, 5, 15, 0);
    chk("sat.dn0", 32'(count_out), 0);
    sat_mode = 1'b0;
`endif

    // randomized run against the model
    begin
      int lim;
      lim = 40;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 49) == 0) lim = $urandom_range(0, 255);
`ifdef UPDOWN_COUNTER_SATURATE_EN
        sat_mode = 1'($urandom_range(0, 1));
`endif
        cyc("rnd", $urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0,
            $urandom_range(0, 255), $urandom_range(0, 9) < 7,
            1'($urandom_range(0, 1)), $urandom_range(0, 15), lim,
            $urandom_range(0, 15) == 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/updown_counter_gen2.md
Name: updown_counter_gen2

Overview:
- Second-generation loadable up/down counter for the verification test environment.
- Over the first-generation counter it adds:
  - a programmable terminal value (`limit`), i.e. a runtime modulus;
  - a variable step size;
  - a registered wrap pulse;
  - sticky overflow/underflow status with software clear.
- Used as an event/timebase counter behind the counter interface; `zero`/`max_count` semantics are preserved so existing checkers still apply.

Parameters:
- WIDTH, 8, counter/data/limit width in bits (≥ 2).
- STEP_W, 4, step input width in bits (1 ≤ STEP_W ≤ WIDTH).
- RESET_VAL, 0, `count_out` value after reset (must be ≤ reset limit; not checked by RTL).

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- load_n  in  1  active-low load strobe
- data_load  in  WIDTH  value loaded when load_n=0
- ce  in  1  count enable
- up_down  in  1  1=count up, 0=count down
- step  in  STEP_W  increment/decrement amount
- limit  in  WIDTH  terminal value; legal count range is 0..limit
- clr_sticky  in  1  clears ovf_sticky/udf_sticky
- count_out  out  WIDTH  registered count
- zero  out  1  combinational, count_out==0
- max_count  out  1  combinational, count_out==limit
- wrap_pulse  out  1  registered, 1-cycle pulse on wrap
- ovf_sticky  out  1  registered, set on up-wrap
- udf_sticky  out  1  registered, set on down-wrap

Behaviour:
- Reset values (rst=1 at a clock edge):
  - count_out=RESET_VAL; wrap_pulse=0; ovf_sticky=0; udf_sticky=0.
  - rst overrides every other input in that cycle, including mid-count and mid-load.
- Priority per edge: rst > load > count > hold.
- Load (load_n=0):
  - count_out <= min(data_load, limit); ce is ignored.
  - wrap_pulse <= 0; stickies unchanged except by clr_sticky.
- Hold (load_n=1, ce=0 or step=0): count_out unchanged; wrap_pulse <= 0.
- Count up (load_n=1, ce=1, up_down=1, step≠0):
  - Compute sum = count_out + step in WIDTH+1 bits.
  - sum ≤ limit → count_out <= sum.
  - sum > limit → count_out <= 0, wrap_pulse <= 1, ovf_sticky <= 1.
- Count down (load_n=1, ce=1, up_down=0, step≠0):
  - step ≤ count_out → count_out <= count_out − step.
  - step > count_out → count_out <= limit, wrap_pulse <= 1, udf_sticky <= 1.
- Out-of-range recovery: if count_out > limit (limit lowered at runtime) and a count step occurs:
  - up → 0;
  - down → limit;
  - wrap_pulse=1 and the matching sticky set.
  - Hold/no-ce leaves count_out unchanged.
- limit=0: every counting step wraps; count_out stays 0; zero=max_count=1.
- Latency: count_out and wrap_pulse update one cycle after the qualifying inputs; zero/max_count follow count_out with no added delay.
- Sticky flags: clr_sticky=1 clears both next cycle; a set in the same cycle wins over the clear.
- No X propagation: all outputs are defined from the first edge with rst=1.

Optional Feature:
- Macro: UPDOWN_COUNTER_SATURATE_EN.
- Defined: adds input port sat_mode (1 bit). When sat_mode=1:
  - up with sum > limit → count_out <= limit;
  - down with step > count_out → count_out <= 0;
  - out-of-range → limit (up) / 0 (down);
  - wrap_pulse and the matching sticky are still asserted.
  - sat_mode=0 behaves as wrap mode.
- Not defined: no sat_mode port; wrap mode only.

Test Plan:
- Reset: drive rst=1 during active counting with count_out=0x37 → next edge count_out=RESET_VAL, all flags 0; zero=1.
- Up wrap: limit=9, load 7, ce=1, up, step=2 → count 9 (max_count=1). Next edge → 0, wrap_pulse=1 for exactly one cycle, ovf_sticky=1.
- Down wrap with step: limit=20, load 3, down, step=4 → count_out=20, udf_sticky=1. clr_sticky=1 in the same cycle as a new down-wrap → udf_sticky stays 1.
- Load priority and clamp: limit=10, load_n=0 with data_load=200, ce=1 → count_out=10, wrap_pulse=0. Load with step=0 and ce=1 → loaded value held.
- Runtime limit drop: count_out=50, set limit=30, up step=1 → count_out=0, wrap_pulse=1. Repeat from 50 with down → 30.
- Saturate (macro defined, sat_mode=1): limit=15, count 14, up step=3 → 15 and stays 15 on further steps, ovf_sticky=1. Down from 2 step=5 → 0.
